stw_scheduler: RTL and testbench



---
 rtl/stw_scheduler_pkg.sv | 24 ++
 rtl/stw_vector_table.sv | 31 +++
 rtl/stw_scheduler.sv | 212 +++++++++++++++++++++
 tb/tb_stw_scheduler.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stw_scheduler_pkg.sv
// Shared definitions for the self-test-window scheduler.
//   - stw_state_e : scheduler FSM state encoding
//   - VEC_SLOT_*  : word slot of each field inside a packed vector-table entry
//                   (entry = {mult_op1, mult_op2, add_op, expected}, op1 in MSBs)
//   - STW_TIMEOUT_DEF : default completion timeout in cycles
package stw_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT      = 3'd1,
    ST_LOAD      = 3'd2,
    ST_ARM       = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_CHECK     = 3'd5
  } stw_state_e;

  localparam int VEC_SLOT_OP1 = 3;
  localparam int VEC_SLOT_OP2 = 2;
  localparam int VEC_SLOT_ADD = 1;
  localparam int VEC_SLOT_EXP = 0;

  localparam int STW_TIMEOUT_DEF = 8;

endpackage

// File: rtl/stw_vector_table.sv
// Test-vector register file for the STW scheduler.
//   clk     : clock
//   wr_en   : write strobe, wr_data stored at wr_idx on the rising edge
//   wr_idx  : write entry index
//   wr_data : packed entry {mult_op1, mult_op2, add_op, expected}
//   rd_idx  : read entry index
//   rd_data : combinational read of entry rd_idx
// Storage is deliberately not reset; entries are undefined until written.
module stw_vector_table
  import stw_scheduler_pkg::*;
#(
  parameter int WORD_SIZE = 16,
  parameter int NUM_VEC   = 4
) (
  input  logic                         clk,
  input  logic                         wr_en,
  input  logic [$clog2(NUM_VEC)-1:0]   wr_idx,
  input  logic [4*WORD_SIZE-1:0]       wr_data,
  input  logic [$clog2(NUM_VEC)-1:0]   rd_idx,
  output logic [4*WORD_SIZE-1:0]       rd_data
);

  logic [4*WORD_SIZE-1:0] mem [NUM_VEC];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/stw_scheduler.sv
// Self-test-window scheduler: periodically runs one table vector on one PE
// through its load/start/complete/result handshake, walking all PE/vector
// pairs round-robin and keeping a sticky per-PE fault map.
//   clk, rst            : clock, async active-low reset
//   enable              : run; 0 returns to IDLE after the current test
//   interval_cfg        : idle cycles between tests (0 behaves as 1)
//   test_allow          : slot grant from the array top FSM
//   vec_wr_*            : vector table write port
//   STW_mult_op1/op2/add_op/expected : broadcast vector, held between LOADs
//   STW_test_load_en    : per-PE load strobe
//   STW_start           : per-PE start pulse
//   STW_complete        : per-PE complete
//   STW_result_out      : per-PE pass(1)/fail(0)
//   fault_clr           : clear fault_map (a same-cycle new fault survives)
//   fault_map           : sticky per-PE fault flags
//   fault_valid/fault_pe_idx : pulse + index when a fault is recorded
//   busy                : test in flight (not IDLE/WAIT)
//   sweep_done          : pulse when the last PE/vector pair is passed
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | scheduler off, waiting for enable
// WAIT       | interval down-counter running
// LOAD       | vector on buses, load strobe to current PE
// ARM        | waiting for test_allow, start pulse in the granted cycle
// WAIT_DONE  | waiting for complete low->high, or timeout
// CHECK      | record result, advance pointer, reload interval
module stw_scheduler
  import stw_scheduler_pkg::*;
#(
  parameter int WORD_SIZE = 16,
  parameter int NUM_PE    = 16,
  parameter int NUM_VEC   = 4,
  parameter int CNT_W     = 16,
  parameter int TIMEOUT   = STW_TIMEOUT_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic [CNT_W-1:0]            interval_cfg,
  input  logic                        test_allow,
  input  logic                        vec_wr_en,
  input  logic [$clog2(NUM_VEC)-1:0]  vec_wr_idx,
  input  logic [4*WORD_SIZE-1:0]      vec_wr_data,
  output logic [WORD_SIZE-1:0]        STW_mult_op1,
  output logic [WORD_SIZE-1:0]        STW_mult_op2,
  output logic [WORD_SIZE-1:0]        STW_add_op,
  output logic [WORD_SIZE-1:0]        STW_expected,
  output logic [NUM_PE-1:0]           STW_test_load_en,
  output logic [NUM_PE-1:0]           STW_start,
  input  logic [NUM_PE-1:0]           STW_complete,
  input  logic [NUM_PE-1:0]           STW_result_out,
  input  logic                        fault_clr,
  output logic [NUM_PE-1:0]           fault_map,
  output logic                        fault_valid,
  output logic [$clog2(NUM_PE)-1:0]   fault_pe_idx,
  output logic                        busy,
  output logic                        sweep_done
);

  localparam int PE_W  = $clog2(NUM_PE);
  localparam int VEC_W = $clog2(NUM_VEC);
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [PE_W-1:0]  PE_LAST  = PE_W'(NUM_PE - 1);
  localparam logic [VEC_W-1:0] VEC_LAST = VEC_W'(NUM_VEC - 1);

  stw_state_e               state, state_nxt;
  logic [CNT_W-1:0]         cnt;
  logic [CNT_W-1:0]         iv_load;
  logic [TMO_W-1:0]         tmo;
  logic                     seen_low;
  logic                     res_pass;
  logic [PE_W-1:0]          pe_idx;
  logic [VEC_W-1:0]         vec_idx;
  logic [4*WORD_SIZE-1:0]   vec_q;
  logic [4*WORD_SIZE-1:0]   tbl_rd;
  logic [NUM_PE-1:0]        fault_map_nxt;
  logic                     advance;
  logic                     reload;
  logic                     capture;
  logic                     done_ok;

  stw_vector_table #(
    .WORD_SIZE (WORD_SIZE),
    .NUM_VEC   (NUM_VEC)
  ) u_table (
    .clk     (clk),
    .wr_en   (vec_wr_en),
    .wr_idx  (vec_wr_idx),
    .wr_data (vec_wr_data),
    .rd_idx  (vec_idx),
    .rd_data (tbl_rd)
  );

  assign iv_load = (interval_cfg == '0) ? CNT_W'(1) : interval_cfg;
  // seen_low is registered so a complete that never dropped cannot pass
  assign done_ok = seen_low && STW_complete[pe_idx];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt        = state;
    advance          = 1'b0;
    reload           = 1'b0;
    capture          = 1'b0;
    STW_test_load_en = '0;
    STW_start        = '0;
    fault_valid      = 1'b0;
    fault_pe_idx     = '0;
    sweep_done       = 1'b0;
    busy             = 1'b1;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (enable) begin
          state_nxt = ST_WAIT;
          reload    = 1'b1;
        end
      end
      ST_WAIT: begin
        busy = 1'b0;
        if (cnt == CNT_W'(1)) begin
          if (!enable) begin
            state_nxt = ST_IDLE;
          end else if (fault_map[pe_idx]) begin
            advance = 1'b1;
            reload  = 1'b1;
          end else begin
            state_nxt = ST_LOAD;
            capture   = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        STW_test_load_en[pe_idx] = 1'b1;
        state_nxt                = ST_ARM;
      end
      ST_ARM: begin
        if (test_allow) begin
          STW_start[pe_idx] = 1'b1;
          state_nxt         = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (done_ok || tmo == TMO_W'(1)) state_nxt = ST_CHECK;
      end
      ST_CHECK: begin
        if (!res_pass) begin
          fault_valid  = 1'b1;
          fault_pe_idx = pe_idx;
        end
        advance   = 1'b1;
        reload    = 1'b1;
        state_nxt = enable ? ST_WAIT : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    sweep_done = advance && (pe_idx == PE_LAST) && (vec_idx == VEC_LAST);
  end

  // A fault recorded in the same cycle as fault_clr survives the clear.
  always_comb begin
    fault_map_nxt = fault_clr ? '0 : fault_map;
    if (fault_valid) fault_map_nxt[pe_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      tmo       <= '0;
      seen_low  <= 1'b0;
      res_pass  <= 1'b0;
      pe_idx    <= '0;
      vec_idx   <= '0;
      vec_q     <= '0;
      fault_map <= '0;
    end else begin
      fault_map <= fault_map_nxt;
      if (reload)               cnt <= iv_load;
      else if (state == ST_WAIT) cnt <= cnt - 1'b1;
      // table is sampled on entry to LOAD, so a write to the driven entry
      // only shows up at the following LOAD
      if (capture) vec_q <= tbl_rd;
      if (state == ST_ARM) begin
        tmo      <= TMO_W'(TIMEOUT);
        seen_low <= 1'b0;
      end else if (state == ST_WAIT_DONE) begin
        if (!STW_complete[pe_idx]) seen_low <= 1'b1;
        if (tmo != '0)             tmo      <= tmo - 1'b1;
        // on timeout done_ok is 0, so the test is recorded as a fail
        res_pass <= done_ok && STW_result_out[pe_idx];
      end
      if (advance) begin
        if (vec_idx == VEC_LAST) begin
          vec_idx <= '0;
          pe_idx  <= (pe_idx == PE_LAST) ? '0 : pe_idx + 1'b1;
        end else begin
          vec_idx <= vec_idx + 1'b1;
        end
      end
    end
  end

  assign STW_mult_op1 = vec_q[VEC_SLOT_OP1*WORD_SIZE +: WORD_SIZE];
  assign STW_mult_op2 = vec_q[VEC_SLOT_OP2*WORD_SIZE +: WORD_SIZE];
  assign STW_add_op   = vec_q[VEC_SLOT_ADD*WORD_SIZE +: WORD_SIZE];
  assign STW_expected = vec_q[VEC_SLOT_EXP*WORD_SIZE +: WORD_SIZE];

endmodule

// File: tb/tb_stw_scheduler.sv
// Directed bench for stw_scheduler with a 4-PE behavioural MAC model.
module tb_stw_scheduler;

  localparam int NPE = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] interval_cfg = '0;
  logic        test_allow = 1'b0;
  logic        vec_wr_en = 1'b0;
  logic [1:0]  vec_wr_idx = '0;
  logic [63:0] vec_wr_data = '0;
  logic [15:0] STW_mult_op1, STW_mult_op2, STW_add_op, STW_expected;
  logic [NPE-1:0] STW_test_load_en, STW_start, STW_complete, STW_result_out;
  logic        fault_clr = 1'b0;
  logic [NPE-1:0] fault_map;
  logic        fault_valid;
  logic [1:0]  fault_pe_idx;
  logic        busy;
  logic        sweep_done;

  stw_scheduler #(.NUM_PE(NPE)) dut (
    .clk(clk), .rst(rst), .enable(enable), .interval_cfg(interval_cfg),
    .test_allow(test_allow), .vec_wr_en(vec_wr_en), .vec_wr_idx(vec_wr_idx),
    .vec_wr_data(vec_wr_data), .STW_mult_op1(STW_mult_op1), .STW_mult_op2(STW_mult_op2),
    .STW_add_op(STW_add_op), .STW_expected(STW_expected),
    .STW_test_load_en(STW_test_load_en), .STW_start(STW_start),
    .STW_complete(STW_complete), .STW_result_out(STW_result_out),
    .fault_clr(fault_clr), .fault_map(fault_map), .fault_valid(fault_valid),
    .fault_pe_idx(fault_pe_idx), .busy(busy), .sweep_done(sweep_done)
  );

  always #5 clk = ~clk;

  // ---------------- PE model ----------------
  logic [NPE-1:0] stuck = '0;     // result forced to fail
  logic [NPE-1:0] tie_high = '0;  // complete never drops
  logic [31:0] calc;
  logic        vec_ok;
  assign calc   = 32'(STW_mult_op1) * 32'(STW_mult_op2) + 32'(STW_add_op);
  assign vec_ok = (calc[15:0] == STW_expected);

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      STW_complete   <= '1;
      STW_result_out <= '0;
    end else begin
      for (int i = 0; i < NPE; i++) begin
        if (STW_start[i] && !tie_high[i]) begin
          STW_complete[i] <= 1'b0;
        end else if (!STW_complete[i]) begin
          STW_complete[i]   <= 1'b1;
          STW_result_out[i] <= vec_ok && !stuck[i];
        end
      end
    end
  end

  // ---------------- event monitor (monotonic totals) ----------------
  int start_cnt [NPE] = '{default: 0};
  int load_tot = 0, sweep_tot = 0, fault_tot = 0, viol = 0;

  always @(negedge clk) begin
    for (int i = 0; i < NPE; i++)
      if (STW_start[i]) start_cnt[i] <= start_cnt[i] + 1;
    if (|STW_test_load_en) load_tot <= load_tot + 1;
    if (sweep_done)        sweep_tot <= sweep_tot + 1;
    if (fault_valid)       fault_tot <= fault_tot + 1;
    if ($countones(STW_start) > 1 || $countones(STW_test_load_en) > 1 ||
        (|STW_start && |STW_test_load_en))
      viol <= viol + 1;
  end

  int start_base [NPE];
  int load_base, sweep_base, fault_base;

  task automatic snap();
    for (int i = 0; i < NPE; i++) start_base[i] = start_cnt[i];
    load_base  = load_tot;
    sweep_base = sweep_tot;
    fault_base = fault_tot;
  endtask

  function automatic int start_delta(input int pe);
    return start_cnt[pe] - start_base[pe];
  endfunction

  function automatic int start_delta_all();
    int s = 0;
    for (int i = 0; i < NPE; i++) s += start_cnt[i] - start_base[i];
    return s;
  endfunction

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  localparam int EV_LOAD = 0, EV_START = 1, EV_FAULT = 2, EV_SWEEP = 3,
                 EV_IDLE = 4, EV_LOAD_ANY = 5, EV_START_ANY = 6;

  function automatic bit ev_hit(input int kind, input int pe);
    case (kind)
      EV_LOAD:      return STW_test_load_en[pe];
      EV_START:     return STW_start[pe];
      EV_FAULT:     return fault_valid;
      EV_SWEEP:     return sweep_done;
      EV_IDLE:      return !busy;
      EV_LOAD_ANY:  return |STW_test_load_en;
      EV_START_ANY: return |STW_start;
      default:      return 1'b0;
    endcase
  endfunction

  // Returns the number of clock edges until the event is seen, -1 on expiry.
  task automatic wait_ev(input int kind, input int pe, input int budget, output int k);
    k = -1;
    for (int i = 1; i <= budget; i++) begin
      @(posedge clk); #1;
      if (ev_hit(kind, pe)) begin
        k = i;
        break;
      end
    end
  endtask

  task automatic wr_vec(input logic [1:0] idx, input logic [63:0] data);
    vec_wr_en   = 1'b1;
    vec_wr_idx  = idx;
    vec_wr_data = data;
    @(posedge clk); #1;
    vec_wr_en = 1'b0;
  endtask

  int k;

  initial begin
    // ---- reset state ----
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ctl", {busy, sweep_done, fault_valid, fault_pe_idx, fault_map,
                         STW_test_load_en, STW_start}, 64'd0);
    check_eq("rst_bus", {STW_mult_op1, STW_mult_op2, STW_add_op, STW_expected}, 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // ---- programming and first-test timing ----
    wr_vec(2'd0, {16'd3,  16'd5,  16'd2, 16'd17});
    wr_vec(2'd1, {16'd4,  16'd4,  16'd1, 16'd17});
    wr_vec(2'd2, {16'd10, 16'd10, 16'd0, 16'd100});
    wr_vec(2'd3, {16'd7,  16'd6,  16'd5, 16'd47});
    interval_cfg = 16'd10;
    test_allow   = 1'b1;
    enable       = 1'b1;
    @(posedge clk); #1;                     // IDLE exit edge
    wait_ev(EV_LOAD, 0, 40, k);
    check_eq("first_load_dly", k, 10);
    check_eq("first_load_op1", STW_mult_op1, 16'd3);
    wait_ev(EV_START, 0, 5, k);
    check_eq("first_start_dly", k, 1);

    // ---- async reset mid-WAIT ----
    wait_ev(EV_IDLE, 0, 20, k);
    check_eq("first_test_end", k, 4);
    @(posedge clk); #1;
    check_eq("bus_hold_op1", STW_expected, 16'd17);
    rst = 1'b0;
    #1;
    check_eq("midwait_rst_ctl", {busy, sweep_done, fault_valid, fault_pe_idx, fault_map,
                                 STW_test_load_en, STW_start}, 64'd0);
    check_eq("midwait_rst_bus", {STW_mult_op1, STW_mult_op2, STW_add_op, STW_expected}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    enable = 1'b0;
    @(posedge clk); #1;

    // ---- all-pass sweep, interval 0 behaves as 1 ----
    snap();
    interval_cfg = 16'd0;
    enable       = 1'b1;
    @(posedge clk); #1;
    wait_ev(EV_LOAD, 0, 10, k);
    check_eq("ival0_load_dly", k, 1);
    wait_ev(EV_SWEEP, 0, 400, k);
    check_eq("sweep1_seen", k > 0, 1);
    @(negedge clk); #1;
    check_eq("sweep1_starts", start_delta_all(), 16);
    check_eq("sweep1_pe3_starts", start_delta(3), 4);
    check_eq("sweep1_done_cnt", sweep_tot - sweep_base, 1);
    check_eq("sweep1_faults", fault_tot - fault_base, 0);
    check_eq("sweep1_fmap", fault_map, 4'b0000);
    wait_ev(EV_LOAD_ANY, 0, 10, k);
    check_eq("wrap_load_pe", STW_test_load_en, 4'b0001);
    check_eq("wrap_vec", {STW_mult_op1, STW_expected}, {16'd3, 16'd17});

    // ---- injected stuck-at-fail on PE2 ----
    stuck[2] = 1'b1;
    wait_ev(EV_START, 2, 400, k);
    check_eq("pe2_start_seen", k > 0, 1);
    wait_ev(EV_FAULT, 0, 10, k);
    check_eq("pe2_fault_dly", k, 3);
    check_eq("pe2_fault_idx", fault_pe_idx, 2'd2);
    snap();
    @(posedge clk); #1;
    check_eq("pe2_fmap", fault_map, 4'b0100);
    wait_ev(EV_SWEEP, 0, 400, k);
    wait_ev(EV_SWEEP, 0, 400, k);
    check_eq("pe2_sweeps_seen", k > 0, 1);
    @(negedge clk); #1;
    check_eq("pe2_skip_starts", start_delta(2), 0);
    check_eq("pe3_starts", start_delta(3), 8);
    check_eq("pe0_starts", start_delta(0), 4);
    check_eq("skip_sweep_cnt", sweep_tot - sweep_base, 2);

    // ---- PE1 timeout ----
    tie_high[1] = 1'b1;
    wait_ev(EV_START, 1, 400, k);
    check_eq("pe1_start_seen", k > 0, 1);
    wait_ev(EV_FAULT, 0, 20, k);
    check_eq("tmo_fault_dly", k, 9);
    check_eq("tmo_fault_idx", fault_pe_idx, 2'd1);
    @(posedge clk); #1;
    check_eq("tmo_fmap", fault_map, 4'b0110);

    // ---- test_allow withheld in ARM ----
    test_allow = 1'b0;
    wait_ev(EV_LOAD_ANY, 0, 400, k);
    check_eq("arm_load_seen", k > 0, 1);
    snap();
    repeat (20) begin
      @(posedge clk); #1;
    end
    check_eq("arm_no_start", start_delta_all(), 0);
    check_eq("arm_busy", busy, 1'b1);
    test_allow = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
    end
    check_eq("arm_one_start", start_delta_all(), 1);

    // ---- enable dropped during WAIT_DONE ----
    wait_ev(EV_START_ANY, 0, 400, k);
    check_eq("drop_start_seen", k > 0, 1);
    @(posedge clk); #1;
    enable = 1'b0;
    wait_ev(EV_IDLE, 0, 20, k);
    check_eq("drop_idle_dly", k, 3);
    snap();
    repeat (30) begin
      @(posedge clk); #1;
    end
    check_eq("drop_no_load", load_tot - load_base, 0);
    check_eq("drop_busy", busy, 1'b0);

    // ---- fault_clr coincident with PE3 fail ----
    stuck[3] = 1'b1;
    enable   = 1'b1;
    wait_ev(EV_START, 3, 400, k);
    check_eq("pe3_start_seen", k > 0, 1);
    wait_ev(EV_FAULT, 0, 10, k);
    check_eq("pe3_fault_idx", fault_pe_idx, 2'd3);
    fault_clr = 1'b1;
    @(posedge clk); #1;
    fault_clr = 1'b0;
    check_eq("clr_fmap", fault_map, 4'b1000);

    check_eq("onehot_viol", viol, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
